// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter takes the slave view; the requester side takes the master view.
interface rr_arbiter_if #(
  parameter int N = 4
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            valid;
  logic            timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority pick from ptr, registered one-hot grant
// held until done, request withdrawal, or MAX_HOLD expiry.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);
  localparam int IDXW = $clog2(N);
  localparam int HW   = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg;
  logic [N-1:0]    grant_reg;
  logic [IDXW-1:0] idx_reg;
  logic [IDXW-1:0] ptr_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            valid_reg;
  logic            timeout_reg;

  logic [IDXW-1:0] win_idx;
  logic [N-1:0]    win_onehot;
  logic [IDXW-1:0] ptr_next;
  logic            any_req;
  logic            hold_expired;
  logic            release_now;

  // Scan offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    int cand;
    cand    = 0;
    win_idx = '0;
    any_req = |bus.req;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr_reg) + off;
      if (cand >= N) cand = cand - N;
      if (bus.req[cand]) win_idx = IDXW'(cand);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == IDXW'(gi));
  end

  assign ptr_next     = (idx_reg == IDXW'(N - 1)) ? '0 : idx_reg + 1'b1;
  assign hold_expired = (hold_cnt_reg == HW'(MAX_HOLD));
  assign release_now  = bus.done || !bus.req[idx_reg] || hold_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      idx_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg    <= win_onehot;
            idx_reg      <= win_idx;
            valid_reg    <= 1'b1;
            hold_cnt_reg <= HW'(1);
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            ptr_reg      <= ptr_next;
            state_reg    <= IDLE;
            // Only a pure expiry counts as a timeout; done or withdrawal win.
            timeout_reg  <= !bus.done && bus.req[idx_reg] && hold_expired;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.grant_idx = idx_reg;
  assign bus.valid     = valid_reg;
  assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: reset, hold/done, rotation, wrap, timeout,
// withdrawal and mid-grant reset scenarios.
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rr_arbiter_if #(.N(4)) bus ();

  rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0000 || bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: grant=%b valid=%b timeout=%b, required 0000/0/0",
                 i, bus.grant, bus.valid, bus.timeout);
      end
    end
    rst     = 1'b0;
    bus.req = 4'b0000;
    $display("test_reset done");
  endtask

  task automatic test_hold_done();
    do_reset();
    bus.req = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.valid !== 1'b1 || bus.grant_idx !== 2'd0) begin
        errors++;
        $display("FAIL hold_done cyc%0d: grant=%b valid=%b idx=%0d, required 0001/1/0",
                 i, bus.grant, bus.valid, bus.grant_idx);
      end
      if (i == 3) bus.done = 1'b1;
    end
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.grant !== 4'b0000 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_done idle: grant=%b valid=%b, required 0000/0", bus.grant, bus.valid);
    end
    // ptr should now be 1: with requesters 0 and 1, requester 1 wins.
    bus.req = 4'b0011;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.grant_idx !== 2'd1 || bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL hold_done ptr: valid=%b idx=%0d grant=%b, required 1/1/0010",
               bus.valid, bus.grant_idx, bus.grant);
    end
    $display("test_hold_done done");
  endtask

  task automatic test_rotation();
    int exp_seq [9] = '{0, -1, 1, -1, 2, -1, 3, -1, 0};
    logic [3:0] exp_grant;
    do_reset();
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (exp_seq[i] < 0) begin
        if (bus.valid !== 1'b0 || bus.grant !== 4'b0000) begin
          errors++;
          $display("FAIL rotation step%0d: valid=%b grant=%b, required idle", i, bus.valid, bus.grant);
        end
      end else begin
        exp_grant = 4'b0001 << exp_seq[i];
        if (bus.valid !== 1'b1 || bus.grant_idx !== 2'(exp_seq[i]) || bus.grant !== exp_grant) begin
          errors++;
          $display("FAIL rotation step%0d: valid=%b idx=%0d grant=%b, required 1/%0d/%b",
                   i, bus.valid, bus.grant_idx, bus.grant, exp_seq[i], exp_grant);
        end
      end
    end
    bus.done = 1'b0;
    $display("test_rotation done");
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    repeat (6) tick();   // serve 0,1,2 -> ptr=3, now idle
    bus.req = 4'b0110;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.grant_idx !== 2'd1 || bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL wrap first: valid=%b idx=%0d grant=%b, required 1/1/0010",
               bus.valid, bus.grant_idx, bus.grant);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap idle: valid=%b, required 0", bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.grant_idx !== 2'd2 || bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL wrap second: valid=%b idx=%0d grant=%b, required 1/2/0100",
               bus.valid, bus.grant_idx, bus.grant);
    end
    bus.done = 1'b0;
    $display("test_wrap done");
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0100;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0100 || bus.valid !== 1'b1 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout hold%0d: grant=%b valid=%b timeout=%b, required 0100/1/0",
                 i, bus.grant, bus.valid, bus.timeout);
      end
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.grant !== 4'b0000 || bus.timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout release: valid=%b grant=%b timeout=%b, required 0/0000/1",
               bus.valid, bus.grant, bus.timeout);
    end
    tick();
    checks++;
    if (bus.grant !== 4'b0100 || bus.grant_idx !== 2'd2 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout regrant: grant=%b idx=%0d timeout=%b, required 0100/2/0",
               bus.grant, bus.grant_idx, bus.timeout);
    end
    // Hold to the limit again, then assert done on the last cycle: done wins.
    repeat (7) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout done_tie: valid=%b timeout=%b, required 0/0", bus.valid, bus.timeout);
    end
    $display("test_timeout done");
  endtask

  task automatic test_withdraw_and_reset();
    do_reset();
    bus.req = 4'b0010;
    tick();
    checks++;
    if (bus.grant_idx !== 2'd1 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL withdraw grant: idx=%0d valid=%b, required 1/1", bus.grant_idx, bus.valid);
    end
    bus.req = 4'b1001;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.grant !== 4'b0000 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL withdraw release: valid=%b grant=%b timeout=%b, required 0/0000/0",
               bus.valid, bus.grant, bus.timeout);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.grant_idx !== 2'd3 || bus.grant !== 4'b1000) begin
      errors++;
      $display("FAIL withdraw next: valid=%b idx=%0d grant=%b, required 1/3/1000",
               bus.valid, bus.grant_idx, bus.grant);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.grant !== 4'b0000 || bus.timeout !== 1'b0 || bus.grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL midgrant_reset: valid=%b grant=%b timeout=%b idx=%0d, required 0/0000/0/0",
               bus.valid, bus.grant, bus.timeout, bus.grant_idx);
    end
    rst     = 1'b0;
    bus.req = 4'b1111;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL midgrant_reset ptr: valid=%b idx=%0d, required 1/0", bus.valid, bus.grant_idx);
    end
    $display("test_withdraw_and_reset done");
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    test_reset();
    test_hold_done();
    test_rotation();
    test_wrap();
    test_timeout();
    test_withdraw_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
